sync_fifo_mem: RTL and testbench

- Single-clock, parametrised FIFO with storage, read/write pointers, occupancy count and status flags in one block.
- Successor to the dual-port byte RAM: data width and depth are generic, and DEPTH need not be a power of two.
- Sits between producer and consumer stages in a single clock domain. Pointer logic is internal; callers never drive addresses.

---
 rtl/sync_fifo_mem.sv | 160 ++++++++++++++++
 tb/tb_sync_fifo_mem.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
// -----------------------------------------------------------------------------
// Single-clock FIFO with its own storage, read/write pointers, occupancy count
// and registered status flags. DEPTH may be any integer >= 2; the pointers
// wrap explicitly at DEPTH-1 rather than relying on power-of-two rollover.
//
// Parameters:
//   WIDTH     data word width in bits
//   DEPTH     number of entries
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk           single clock, all logic on posedge
//   rst           synchronous reset, active-high
//   wr_en/wr_data write request and its data
//   rd_en         read request
//   rd_data       registered read data, valid one cycle after an accepted read
//   rd_valid      one-cycle pulse when rd_data carries a newly popped word
//   full, empty, almost_full, almost_empty   registered status flags
//   count         current occupancy
//   overflow      sticky: write requested but not accepted
//   underflow     sticky: read requested while empty
//   err_clr       clears overflow/underflow
//
// Build option:
//   SYNC_FIFO_ERR_FLAGS_EN  when defined, overflow/underflow are live sticky
//                           flags; when undefined they are tied to 0 and
//                           err_clr is ignored (ports remain present).
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 90,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [31:0]   AF_THRESH = 32'(AF_LEVEL);
  localparam logic [31:0]   AE_THRESH = 32'(AE_LEVEL);

  // Reset values of the threshold flags depend on the configured levels.
  localparam logic AF_RESET = (AF_LEVEL <= 0);
  localparam logic AE_RESET = (AE_LEVEL >= 0);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [CW-1:0] count_next;
  logic [31:0]   count_next_ext;

  // Accept logic. A write into a full FIFO is allowed only when a read
  // frees a slot in the same cycle; there is no empty-FIFO bypass, so a
  // read against an empty FIFO is always rejected.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
  end

  // Next-state occupancy; the flags are registered from this value so they
  // line up with count in the same cycle.
  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CW'(1);
    end
    count_next_ext = 32'(count_next);
  end

  // Storage array: not reset. When full, rd_ptr == wr_ptr, and the
  // non-blocking read below still returns the old (oldest) word before the
  // simultaneous write replaces it.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, count, flags and read data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= AE_RESET;
      almost_full  <= AF_RESET;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid     <= rd_acc;
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == CNT_DEPTH);
      almost_full  <= (count_next_ext >= AF_THRESH);
      almost_empty <= (count_next_ext <= AE_THRESH);
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // Sticky error flags. A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  // Error tracking disabled: flags are constant and err_clr has no effect.
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_mem.sv
// tb_sync_fifo_mem
// -----------------------------------------------------------------------------
// Directed bench for sync_fifo_mem with WIDTH=8, DEPTH=5, AF_LEVEL=4,
// AE_LEVEL=1. Expected values are hand-computed; the error-flag expectations
// follow SYNC_FIFO_ERR_FLAGS_EN if it is defined for the build.
// -----------------------------------------------------------------------------
module tb_sync_fifo_mem;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  int vecCount  = 0;
  int missCount = 0;

  sync_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AF_LEVEL(4),
    .AE_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .err_clr(err_clr)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge
  task automatic applyStimulus(input logic r, input logic we,
                               input logic [WIDTH-1:0] wd, input logic re,
                               input logic ec);
    rst     = r;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [WIDTH-1:0] wd);
    applyStimulus(1'b0, 1'b1, wd, 1'b0, 1'b0);
  endtask

  task automatic readWord();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] exp1 [3];
    logic [7:0] exp3 [5];
    exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33;
    exp3[0] = 8'h02; exp3[1] = 8'h03; exp3[2] = 8'h04; exp3[3] = 8'h05;
    exp3[4] = 8'hAA;

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ae", 32'(almost_empty), 32'd1);
    checkOutput("rst_af", 32'(almost_full), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_unf", 32'(underflow), 32'd0);

    // Write three, read three in order
    writeWord(8'h11);
    checkOutput("t1_cnt1", 32'(count), 32'd1);
    checkOutput("t1_ae1", 32'(almost_empty), 32'd1);
    writeWord(8'h22);
    writeWord(8'h33);
    checkOutput("t1_cnt3", 32'(count), 32'd3);
    checkOutput("t1_empty3", 32'(empty), 32'd0);
    checkOutput("t1_ae3", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 3; i++) begin
      readWord();
      checkOutput("t1_rd_data", 32'(rd_data), 32'(exp1[i]));
      checkOutput("t1_rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("t1_cnt", 32'(count), 32'(2 - i));
    end
    checkOutput("t1_empty_end", 32'(empty), 32'd1);
    idle();
    checkOutput("t1_valid_drop", 32'(rd_valid), 32'd0);
    checkOutput("t1_data_hold", 32'(rd_data), 32'h33);

    // Fill to full, then an ignored extra write
    for (int i = 1; i <= 5; i++) begin
      writeWord(8'(i));
      checkOutput("t2_cnt", 32'(count), 32'(i));
      checkOutput("t2_af", 32'(almost_full), (i >= 4) ? 32'd1 : 32'd0);
      checkOutput("t2_full", 32'(full), (i == 5) ? 32'd1 : 32'd0);
    end
    writeWord(8'h66);
    checkOutput("t2_ovf_cnt", 32'(count), 32'd5);
    checkOutput("t2_ovf_full", 32'(full), 32'd1);
    checkOutput("t2_ovf_flag", 32'(overflow), ERR_EXP);

    // Simultaneous read/write while full
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("t3_rw_data", 32'(rd_data), 32'h01);
    checkOutput("t3_rw_valid", 32'(rd_valid), 32'd1);
    checkOutput("t3_rw_cnt", 32'(count), 32'd5);
    checkOutput("t3_rw_full", 32'(full), 32'd1);
    checkOutput("t3_ovf_sticky", 32'(overflow), ERR_EXP);
    for (int i = 0; i < 5; i++) begin
      readWord();
      checkOutput("t3_drain_data", 32'(rd_data), 32'(exp3[i]));
      checkOutput("t3_drain_cnt", 32'(count), 32'(4 - i));
    end
    checkOutput("t3_empty", 32'(empty), 32'd1);

    // Simultaneous read/write while empty: write only
    applyStimulus(1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
    checkOutput("t4_valid", 32'(rd_valid), 32'd0);
    checkOutput("t4_cnt", 32'(count), 32'd1);
    checkOutput("t4_unf", 32'(underflow), ERR_EXP);
    readWord();
    checkOutput("t4_data", 32'(rd_data), 32'h5C);
    checkOutput("t4_valid2", 32'(rd_valid), 32'd1);
    checkOutput("t4_cnt0", 32'(count), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t4_clr_unf", 32'(underflow), 32'd0);
    checkOutput("t4_clr_ovf", 32'(overflow), 32'd0);

    // Interleaved write/read, pointers wrap repeatedly
    for (int i = 0; i < 12; i++) begin
      writeWord(8'(8'h80 + i));
      checkOutput("t5_cnt_w", 32'(count), 32'd1);
      readWord();
      checkOutput("t5_data", 32'(rd_data), 32'(8'h80 + i));
      checkOutput("t5_valid", 32'(rd_valid), 32'd1);
      checkOutput("t5_cnt_r", 32'(count), 32'd0);
    end

    // Mid-stream reset
    writeWord(8'hC1);
    writeWord(8'hC2);
    writeWord(8'hC3);
    checkOutput("t6_cnt3", 32'(count), 32'd3);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("t6_cnt", 32'(count), 32'd0);
    checkOutput("t6_empty", 32'(empty), 32'd1);
    checkOutput("t6_valid", 32'(rd_valid), 32'd0);
    checkOutput("t6_data", 32'(rd_data), 32'd0);
    readWord();
    checkOutput("t6_stale_valid", 32'(rd_valid), 32'd0);
    checkOutput("t6_stale_cnt", 32'(count), 32'd0);
    checkOutput("t6_unf", 32'(underflow), ERR_EXP);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
